// File: rtl/to_local_merge.sv
// to_local_merge: drains packets addressed to this core from the north and
// south arrival buffers. It arbitrates between the two buffers in round-robin
// order, strips the routing header and presents {tick, axon} to the scheduler
// over a valid/ack handshake. A packet with a nonzero dx or dy is dropped and
// sets the sticky misroute flag.
// Optional macro TO_LOCAL_MISROUTE_CNT_EN adds an 8-bit saturating count of
// dropped packets (port misroute_cnt).
module to_local_merge #(
   parameter int unsigned PACKET_WIDTH = 30,
   parameter int unsigned DX_MSB       = 29,
   parameter int unsigned DX_LSB       = 21,
   parameter int unsigned DY_MSB       = 20,
   parameter int unsigned DY_LSB       = 12,
   parameter int unsigned TICK_MSB     = 11,
   parameter int unsigned TICK_LSB     = 8,
   parameter int unsigned AXON_MSB     = 7,
   parameter int unsigned AXON_LSB     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PACKET_WIDTH-1:0]      din_north,
   input  logic                         empty_north,
   output logic                         ren_north,
   input  logic [PACKET_WIDTH-1:0]      din_south,
   input  logic                         empty_south,
   output logic                         ren_south,
   output logic [TICK_MSB-TICK_LSB:0]   tick_out,
   output logic [AXON_MSB-AXON_LSB:0]   axon_out,
   output logic                         valid_out,
   input  logic                         ack_in,
`ifdef TO_LOCAL_MISROUTE_CNT_EN
   output logic                         misroute,
   output logic [7:0]                   misroute_cnt
`else
   output logic                         misroute
`endif
);

   typedef enum logic {StEmpty, StFull} state_e;
   typedef enum logic {PtrNorth, PtrSouth} ptr_e;

   state_e                       state_q, state_d;
   ptr_e                         ptr_q, ptr_d;
   logic [TICK_MSB-TICK_LSB:0]   tick_q, tick_d;
   logic [AXON_MSB-AXON_LSB:0]   axon_q, axon_d;
   logic                         misroute_q, misroute_d;

   logic                         slot_free;
   logic                         grant_n, grant_s, grant;
   logic [PACKET_WIDTH-1:0]      pkt;
   logic                         dest_ok;
   logic                         drop;

   // Round-robin grant; never grant during reset or onto an empty buffer.
   always_comb begin
      slot_free = (state_q == StEmpty) || ack_in;
      grant_n   = 1'b0;
      grant_s   = 1'b0;
      if (!rst && slot_free) begin
         grant_n = !empty_north && (empty_south || ptr_q == PtrNorth);
         grant_s = !empty_south && (empty_north || ptr_q == PtrSouth);
      end
      grant     = grant_n || grant_s;
      pkt       = grant_n ? din_north : din_south;
      dest_ok   = (pkt[DX_MSB:DX_LSB] == '0) && (pkt[DY_MSB:DY_LSB] == '0);
      drop      = grant && !dest_ok;
      ren_north = grant_n;
      ren_south = grant_s;
   end

   // Output-stage next state, pointer rotation and sticky misroute flag.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tick_d     = tick_q;
      axon_d     = axon_q;
      misroute_d = misroute_q;
      if (grant) begin
         ptr_d = grant_n ? PtrSouth : PtrNorth;
         if (dest_ok) begin
            state_d = StFull;
            tick_d  = pkt[TICK_MSB:TICK_LSB];
            axon_d  = pkt[AXON_MSB:AXON_LSB];
         end else begin
            // A grant implies the slot is free, so any held packet is consumed.
            state_d    = StEmpty;
            misroute_d = 1'b1;
         end
      end else if (state_q == StFull && ack_in) begin
         state_d = StEmpty;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StEmpty;
         ptr_q      <= PtrNorth;
         tick_q     <= '0;
         axon_q     <= '0;
         misroute_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tick_q     <= tick_d;
         axon_q     <= axon_d;
         misroute_q <= misroute_d;
      end
   end

   assign valid_out = (state_q == StFull);
   assign tick_out  = tick_q;
   assign axon_out  = axon_q;
   assign misroute  = misroute_q;

`ifdef TO_LOCAL_MISROUTE_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   // Saturating count of dropped packets.
   always_comb begin
      cnt_d = cnt_q;
      if (drop && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign misroute_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_to_local_merge.sv
// Self-checking bench for to_local_merge: a table of single-cycle vectors
// followed by queue-driven sequences for streaming, backpressure, misroute
// and asynchronous reset.
module tb_to_local_merge;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] din_north, din_south;
   logic        empty_north, empty_south;
   logic        ren_north, ren_south;
   logic [3:0]  tick_out;
   logic [7:0]  axon_out;
   logic        valid_out;
   logic        ack_in;
   logic        misroute;
`ifdef TO_LOCAL_MISROUTE_CNT_EN
   logic [7:0]  misroute_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [29:0] qn[$];
   logic [29:0] qs[$];

   to_local_merge dut (
      .clk         (clk),
      .rst         (rst),
      .din_north   (din_north),
      .empty_north (empty_north),
      .ren_north   (ren_north),
      .din_south   (din_south),
      .empty_south (empty_south),
      .ren_south   (ren_south),
      .tick_out    (tick_out),
      .axon_out    (axon_out),
      .valid_out   (valid_out),
      .ack_in      (ack_in),
`ifdef TO_LOCAL_MISROUTE_CNT_EN
      .misroute    (misroute),
      .misroute_cnt(misroute_cnt)
`else
      .misroute    (misroute)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] n;
      logic        n_ne;
      logic [29:0] s;
      logic        s_ne;
      logic        ack;
      logic        rn;
      logic        rs;
      logic        v;
      logic [3:0]  t;
      logic [7:0]  a;
      logic        m;
      logic [7:0]  c;
   } vec_t;

   function automatic logic [29:0] pk(input int dx, input int dy, input int tick, input int axon);
      logic [8:0] dxv;
      logic [8:0] dyv;
      logic [3:0] tv;
      logic [7:0] av;
      dxv = dx[8:0];
      dyv = dy[8:0];
      tv  = tick[3:0];
      av  = axon[7:0];
      return {dxv, dyv, tv, av};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive();
      empty_north = (qn.size() == 0);
      empty_south = (qs.size() == 0);
      din_north   = (qn.size() != 0) ? qn[0] : '0;
      din_south   = (qs.size() != 0) ? qs[0] : '0;
   endtask

   // One clock from the buffer queues; returns the read enables seen before the edge.
   task automatic run_cycle(input logic ack, output logic rn, output logic rs);
      drive();
      ack_in = ack;
      #1;
      rn = ren_north;
      rs = ren_south;
      @(posedge clk);
      if (rn && qn.size() != 0) void'(qn.pop_front());
      if (rs && qs.size() != 0) void'(qs.pop_front());
      #1;
      drive();
   endtask

   task automatic do_reset();
      qn.delete();
      qs.delete();
      drive();
      ack_in = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t vecs[14];
   logic rn, rs;
   logic [7:0] exp_seq[6];

   initial begin
      rst         = 1'b1;
      ack_in      = 1'b0;
      din_north   = '0;
      din_south   = '0;
      empty_north = 1'b1;
      empty_south = 1'b1;
      #2;
      chk("reset_valid", {31'd0, valid_out}, 32'd0);
      chk("reset_ren", {30'd0, ren_north, ren_south}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      //          n                   n_ne s                   s_ne ack  rn   rs   v    t     a      m    c
      vecs[0]  = '{'0,                0,   '0,                 0,   0,   0,   0,   0,   4'd0, 8'h00, 0,   8'd0};
      vecs[1]  = '{pk(0,0,3,8'h2A),   1,   '0,                 0,   1,   1,   0,   1,   4'd3, 8'h2A, 0,   8'd0};
      vecs[2]  = '{'0,                0,   '0,                 0,   0,   0,   0,   1,   4'd3, 8'h2A, 0,   8'd0};
      vecs[3]  = '{pk(0,0,1,1),       1,   pk(0,0,2,11),       1,   0,   0,   0,   1,   4'd3, 8'h2A, 0,   8'd0};
      vecs[4]  = '{pk(0,0,1,1),       1,   pk(0,0,2,11),       1,   1,   0,   1,   1,   4'd2, 8'd11, 0,   8'd0};
      vecs[5]  = '{pk(0,0,1,1),       1,   pk(0,0,2,11),       1,   1,   1,   0,   1,   4'd1, 8'd1,  0,   8'd0};
      vecs[6]  = '{'0,                0,   pk(-1,0,4,7),       1,   0,   0,   0,   1,   4'd1, 8'd1,  0,   8'd0};
      vecs[7]  = '{'0,                0,   pk(-1,0,4,7),       1,   1,   0,   1,   0,   4'd1, 8'd1,  1,   8'd1};
      vecs[8]  = '{'0,                0,   '0,                 0,   1,   0,   0,   0,   4'd1, 8'd1,  1,   8'd1};
      vecs[9]  = '{pk(0,1,5,9),       1,   pk(0,0,6,8'h33),    1,   0,   1,   0,   0,   4'd1, 8'd1,  1,   8'd2};
      vecs[10] = '{pk(0,1,5,9),       1,   pk(0,0,6,8'h33),    1,   0,   0,   1,   1,   4'd6, 8'h33, 1,   8'd2};
      vecs[11] = '{pk(0,0,7,8'hFF),   1,   '0,                 0,   1,   1,   0,   1,   4'd7, 8'hFF, 1,   8'd2};
      vecs[12] = '{'0,                0,   '0,                 0,   1,   0,   0,   0,   4'd7, 8'hFF, 1,   8'd2};
      vecs[13] = '{pk(1,0,2,3),       1,   '0,                 0,   0,   1,   0,   0,   4'd7, 8'hFF, 1,   8'd3};

      for (int i = 0; i < 14; i++) begin
         din_north   = vecs[i].n;
         empty_north = !vecs[i].n_ne;
         din_south   = vecs[i].s;
         empty_south = !vecs[i].s_ne;
         ack_in      = vecs[i].ack;
         #1;
         chk($sformatf("vec%0d_ren_north", i), {31'd0, ren_north}, {31'd0, vecs[i].rn});
         chk($sformatf("vec%0d_ren_south", i), {31'd0, ren_south}, {31'd0, vecs[i].rs});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, {31'd0, vecs[i].v});
         chk($sformatf("vec%0d_tick", i), {28'd0, tick_out}, {28'd0, vecs[i].t});
         chk($sformatf("vec%0d_axon", i), {24'd0, axon_out}, {24'd0, vecs[i].a});
         chk($sformatf("vec%0d_misroute", i), {31'd0, misroute}, {31'd0, vecs[i].m});
`ifdef TO_LOCAL_MISROUTE_CNT_EN
         chk($sformatf("vec%0d_cnt", i), {24'd0, misroute_cnt}, {24'd0, vecs[i].c});
`endif
      end

      // Full-rate alternation with both buffers loaded.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         qn.push_back(pk(0, 0, 0, i + 1));
         qs.push_back(pk(0, 0, 0, i + 11));
      end
      exp_seq = '{8'd1, 8'd11, 8'd2, 8'd12, 8'd3, 8'd13};
      for (int i = 0; i < 6; i++) begin
         run_cycle(1'b1, rn, rs);
         chk($sformatf("stream%0d_valid", i), {31'd0, valid_out}, 32'd1);
         chk($sformatf("stream%0d_axon", i), {24'd0, axon_out}, {24'd0, exp_seq[i]});
      end
      run_cycle(1'b1, rn, rs);
      chk("stream_drain_valid", {31'd0, valid_out}, 32'd0);

      // Backpressure holds the output, then reloads with no bubble.
      do_reset();
      qn.push_back(pk(0, 0, 4, 5));
      qn.push_back(pk(0, 0, 4, 6));
      qs.push_back(pk(0, 0, 9, 20));
      run_cycle(1'b0, rn, rs);
      chk("bp_load_axon", {24'd0, axon_out}, 32'd5);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b0, rn, rs);
         chk($sformatf("bp%0d_ren", i), {30'd0, rn, rs}, 32'd0);
         chk($sformatf("bp%0d_hold", i), {19'd0, valid_out, tick_out, axon_out}, {19'd0, 1'b1, 4'd4, 8'd5});
      end
      run_cycle(1'b1, rn, rs);
      chk("bp_release_ren", {30'd0, rn, rs}, 32'd1);
      chk("bp_release_out", {19'd0, valid_out, tick_out, axon_out}, {19'd0, 1'b1, 4'd9, 8'd20});

      // Misrouted south packet is dropped, a later valid packet still flows.
      do_reset();
      qs.push_back(pk(-1, 0, 4, 7));
      run_cycle(1'b1, rn, rs);
      chk("mis_ren_south", {30'd0, rn, rs}, 32'd1);
      chk("mis_valid", {31'd0, valid_out}, 32'd0);
      chk("mis_flag", {31'd0, misroute}, 32'd1);
`ifdef TO_LOCAL_MISROUTE_CNT_EN
      chk("mis_cnt", {24'd0, misroute_cnt}, 32'd1);
`endif
      qn.push_back(pk(0, 0, 2, 8'h44));
      run_cycle(1'b1, rn, rs);
      chk("mis_next_out", {19'd0, valid_out, tick_out, axon_out}, {19'd0, 1'b1, 4'd2, 8'h44});
      chk("mis_sticky", {31'd0, misroute}, 32'd1);

      // Asynchronous reset between edges while a packet is held (pointer is SOUTH).
      #3;
      qn.push_back(pk(0, 0, 1, 1));
      qs.push_back(pk(0, 0, 1, 2));
      qn.delete(); qs.delete();
      qn.push_back(pk(0, 0, 1, 1));
      qs.push_back(pk(0, 0, 1, 2));
      drive();
      rst = 1'b1;
      #1;
      chk("arst_out", {18'd0, valid_out, tick_out, axon_out, misroute}, 32'd0);
      chk("arst_ren", {30'd0, ren_north, ren_south}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_cycle(1'b1, rn, rs);
      chk("arst_first_grant", {30'd0, rn, rs}, 32'd2);
      chk("arst_first_axon", {24'd0, axon_out}, 32'd1);
      run_cycle(1'b1, rn, rs);
      chk("arst_second_axon", {24'd0, axon_out}, 32'd2);

`ifdef TO_LOCAL_MISROUTE_CNT_EN
      // Counter saturation.
      do_reset();
      for (int i = 0; i < 300; i++) qn.push_back(pk(3, 0, 0, i));
      for (int i = 0; i < 400 && qn.size() != 0; i++) run_cycle(1'b0, rn, rs);
      chk("sat_drained", qn.size(), 32'd0);
      chk("sat_cnt", {24'd0, misroute_cnt}, 32'd255);
      chk("sat_flag", {31'd0, misroute}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
